// File: rtl/jtag_master.sv
// jtag_master: brings the target TAP to Run-Test/Idle after reset, then runs
// single IR or DR scans on request. Each TCK period takes two system clocks
// (low phase, then high phase); tms/tdi change only when a low phase begins and
// tdo is sampled on the clock edge that ends a high phase.
module jtag_master #(
  parameter int max_len = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     is_ir,
  input  logic [$clog2(max_len):0] length,
  input  logic [max_len-1:0]       tdi_data,
  input  logic                     tdo,
  output logic                     tck,
  output logic                     tms,
  output logic                     tdi,
  output logic                     busy,
  output logic                     done,
  output logic [max_len-1:0]       tdo_data
);

  localparam int LW = $clog2(max_len) + 1;
  localparam int CW = (LW > 3) ? LW : 3;
  localparam logic [LW-1:0] MaxLen = LW'(max_len);

  typedef enum logic [2:0] {
    TLR_SEQ,
    IDLE,
    HEADER,
    SHIFT,
    TRAILER,
    FIN
  } state_e;

  state_e             state_q, state_d;
  logic               phase_q, phase_d;
  logic [CW-1:0]      bitCnt_q, bitCnt_d;
  logic               isIr_q, isIr_d;
  logic [LW-1:0]      len_q, len_d;
  logic [max_len-1:0] data_q, data_d;
  logic [max_len-1:0] tdoData_q, tdoData_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [CW-1:0]      lastIdx;
  logic [CW-1:0]      hdrLast;
  logic [max_len-1:0] tdoBit;

  assign lastIdx = CW'(len_q) - CW'(1);
  assign hdrLast = isIr_q ? CW'(3) : CW'(2);

  // State and registered JTAG pins; reset parks the pins at the TLR start values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= TLR_SEQ;
      phase_q   <= 1'b0;
      bitCnt_q  <= '0;
      isIr_q    <= 1'b0;
      len_q     <= '0;
      data_q    <= '0;
      tdoData_q <= '0;
      tck_q     <= 1'b0;
      tms_q     <= 1'b1;
      tdi_q     <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bitCnt_q  <= bitCnt_d;
      isIr_q    <= isIr_d;
      len_q     <= len_d;
      data_q    <= data_d;
      tdoData_q <= tdoData_d;
      tck_q     <= tck_d;
      tms_q     <= tms_d;
      tdi_q     <= tdi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state: advance phase/period counters, capture a request, collect tdo bits.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bitCnt_d  = bitCnt_q;
    isIr_d    = isIr_q;
    len_d     = len_q;
    data_d    = data_q;
    tdoData_d = tdoData_q;
    tdoBit    = '0;
    tdoBit[0] = tdo;
    unique case (state_q)
      TLR_SEQ: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (bitCnt_q == CW'(5)) begin
            state_d  = IDLE;
            bitCnt_d = '0;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
      IDLE: begin
        if (start && (length != '0)) begin
          state_d   = HEADER;
          phase_d   = 1'b0;
          bitCnt_d  = '0;
          isIr_d    = is_ir;
          len_d     = (length > MaxLen) ? MaxLen : length;
          data_d    = tdi_data;
          tdoData_d = '0;
        end
      end
      HEADER: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (bitCnt_q == hdrLast) begin
            state_d  = SHIFT;
            bitCnt_d = '0;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
      SHIFT: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          tdoData_d = tdoData_q | (tdoBit << bitCnt_q);
          if (bitCnt_q >= lastIdx) begin
            state_d  = TRAILER;
            bitCnt_d = '0;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
            data_d   = data_q >> 1;
          end
        end
      end
      TRAILER: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (bitCnt_q == CW'(1)) begin
            state_d  = FIN;
            bitCnt_d = '0;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        phase_d = 1'b0;
      end
      default: begin
        state_d  = TLR_SEQ;
        phase_d  = 1'b0;
        bitCnt_d = '0;
      end
    endcase
  end

  // Output: pin values for the upcoming state/period, registered next clock.
  always_comb begin
    tck_d  = 1'b0;
    tms_d  = 1'b0;
    tdi_d  = 1'b0;
    busy_d = 1'b1;
    done_d = 1'b0;
    case (state_d)
      TLR_SEQ: begin
        tck_d = phase_d;
        tms_d = (bitCnt_d != CW'(5));
      end
      IDLE: begin
        busy_d = 1'b0;
      end
      HEADER: begin
        tck_d = phase_d;
        tms_d = isIr_d ? (bitCnt_d < CW'(2)) : (bitCnt_d == '0);
      end
      SHIFT: begin
        tck_d = phase_d;
        tms_d = (bitCnt_d == lastIdx);
        tdi_d = data_d[0];
      end
      TRAILER: begin
        tck_d = phase_d;
        tms_d = (bitCnt_d == '0);
      end
      FIN: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        tms_d = 1'b1;
      end
    endcase
  end

  assign tck      = tck_q;
  assign tms      = tms_q;
  assign tdi      = tdi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tdo_data = tdoData_q;

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: directed scans against jtag_master with a TAP state model
// and a 4-cell loopback data register hanging off tck/tms/tdi/tdo.
module tb_jtag_master;

  localparam int MaxLen = 32;

  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
  } tap_e;

  logic              clock   = 1'b0;
  logic              reset_n = 1'b1;
  logic              start;
  logic              isIr;
  logic [5:0]        length;
  logic [MaxLen-1:0] tdiData;
  logic              tdo = 1'b0;
  logic              tck, tms, tdi, busy, done;
  logic [MaxLen-1:0] tdoData;

  int   checkCount = 0;
  int   errorCount = 0;
  int   tckRises   = 0;
  int   shiftEdges = 0;
  int   doneCount  = 0;
  bit   tmsLog[$];
  bit   tdiLog[$];
  tap_e tapState = EX2DR;
  logic [3:0] loopSr = 4'b1010;

  int rise0, shift0, tms0, tdi0, done0;
  int clocks;
  logic busySeen;

  jtag_master #(.max_len(MaxLen)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .is_ir    (isIr),
    .length   (length),
    .tdi_data (tdiData),
    .tdo      (tdo),
    .tck      (tck),
    .tms      (tms),
    .tdi      (tdi),
    .busy     (busy),
    .done     (done),
    .tdo_data (tdoData)
  );

  // System clock, 10 time units per period.
  always #5 clock = ~clock;

  function automatic tap_e nextTap(input tap_e s, input logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PADR;
      PADR:    return m ? EX2DR : PADR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PAIR;
      PAIR:    return m ? EX2IR : PAIR;
      EX2IR:   return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  // Target TAP: logs tms/tdi per rising tck, advances state, shifts the loopback in Shift-DR.
  always @(posedge tck) begin
    tmsLog.push_back(tms);
    tckRises <= tckRises + 1;
    if (tapState == SHDR || tapState == SHIR) begin
      tdiLog.push_back(tdi);
      shiftEdges <= shiftEdges + 1;
    end
    if (tapState == SHDR) loopSr <= {tdi, loopSr[3:1]};
    tapState <= nextTap(tapState, tms);
  end

  // Target drives tdo on the falling tck edge.
  always @(negedge tck) tdo <= loopSr[0];

  // Count done pulses, one per clock they are seen high.
  always @(negedge clock) if (done === 1'b1) doneCount <= doneCount + 1;

  function automatic logic [63:0] packTms(input int from, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n && i < 64; i++) if (from + i < tmsLog.size()) v[i] = tmsLog[from + i];
    return v;
  endfunction

  function automatic logic [63:0] packTdi(input int from, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n && i < 64; i++) if (from + i < tdiLog.size()) v[i] = tdiLog[from + i];
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic markBase();
    rise0  = tckRises;
    shift0 = shiftEdges;
    tms0   = tmsLog.size();
    tdi0   = tdiLog.size();
    done0  = doneCount;
  endtask

  // Presents one request for a single clock; returns at the negedge after it was sampled.
  task automatic applyStimulus(input logic ir, input logic [5:0] len, input logic [MaxLen-1:0] data);
    @(negedge clock);
    isIr    = ir;
    length  = len;
    tdiData = data;
    start   = 1'b1;
    @(negedge clock);
    start   = 1'b0;
  endtask

  task automatic waitDone(input int limit, output int n);
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic waitIdle(input int limit, output int n);
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clock);
      n++;
    end
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1);
  end

  // Directed scenario sequence.
  initial begin
    start   = 1'b0;
    isIr    = 1'b0;
    length  = '0;
    tdiData = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_pins", {tck, tms, tdi, busy, done}, 5'b01010);
    checkOutput("reset_tdo_data", tdoData, 0);

    markBase();
    reset_n = 1'b1;
    waitIdle(40, clocks);
    checkOutput("tlr_busy_clocks", clocks, 12);
    checkOutput("tlr_tck_count", tckRises - rise0, 6);
    checkOutput("tlr_tms_pattern", packTms(tms0, 6), 64'h1F);
    checkOutput("tlr_tap_state", tapState, RTI);
    checkOutput("tlr_idle_pins", {tck, tms, tdi, done}, 0);
    checkOutput("tlr_tdo_data", tdoData, 0);

    markBase();
    applyStimulus(1'b0, 6'd8, 32'hC5);
    checkOutput("dr_busy_rise", busy, 1);
    waitDone(100, clocks);
    checkOutput("dr_done_seen", done, 1);
    checkOutput("dr_clocks", clocks, 26);
    checkOutput("dr_busy_at_done", busy, 0);
    checkOutput("dr_tck_count", tckRises - rise0, 13);
    checkOutput("dr_tms_pattern", packTms(tms0, 13), 64'hC01);
    checkOutput("dr_shift_edges", shiftEdges - shift0, 8);
    checkOutput("dr_tdi_bits", packTdi(tdi0, 8), 64'hC5);
    checkOutput("dr_tdo_data", tdoData, 64'h5A);
    checkOutput("dr_tap_at_done", tapState, RTI);
    @(negedge clock);
    checkOutput("dr_done_width", done, 0);
    checkOutput("dr_done_count", doneCount - done0, 1);
    checkOutput("dr_tdo_hold", tdoData, 64'h5A);

    markBase();
    @(negedge clock);
    isIr = 1'b0; length = 6'd0; tdiData = 32'hFFFF; start = 1'b1;
    busySeen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (busy !== 1'b0) busySeen = 1'b1;
    end
    start = 1'b0;
    checkOutput("len0_busy", busySeen, 0);
    checkOutput("len0_done", doneCount - done0, 0);
    checkOutput("len0_tck", tckRises - rise0, 0);

    markBase();
    applyStimulus(1'b1, 6'd4, 32'hF);
    waitDone(100, clocks);
    checkOutput("ir_done_seen", done, 1);
    checkOutput("ir_clocks", clocks, 20);
    checkOutput("ir_tck_count", tckRises - rise0, 10);
    checkOutput("ir_tms_pattern", packTms(tms0, 10), 64'h183);
    checkOutput("ir_shift_edges", shiftEdges - shift0, 4);
    checkOutput("ir_tdi_bits", packTdi(tdi0, 4), 64'hF);
    checkOutput("ir_tdo_data", tdoData, 0);
    checkOutput("ir_tap_at_done", tapState, RTI);
    @(negedge clock);

    markBase();
    applyStimulus(1'b0, 6'd40, 32'h12345678);
    waitDone(200, clocks);
    checkOutput("clamp_done_seen", done, 1);
    checkOutput("clamp_clocks", clocks, 74);
    checkOutput("clamp_tck_count", tckRises - rise0, 37);
    checkOutput("clamp_shift_edges", shiftEdges - shift0, 32);
    checkOutput("clamp_tdi_bits", packTdi(tdi0, 32), 64'h12345678);
    checkOutput("clamp_tdo_data", tdoData, 64'h2345678C);
    checkOutput("clamp_tap_at_done", tapState, RTI);
    @(negedge clock);

    markBase();
    @(negedge clock);
    isIr = 1'b0; length = 6'd2; tdiData = 32'h3; start = 1'b1;
    @(negedge clock);
    waitDone(100, clocks);
    checkOutput("held_clocks", clocks, 14);
    checkOutput("held_busy_at_done", busy, 0);
    @(negedge clock);
    checkOutput("held_idle_gap", {done, busy}, 0);
    @(negedge clock);
    checkOutput("held_restart", busy, 1);
    start = 1'b0;
    waitDone(100, clocks);
    checkOutput("held_second_clocks", clocks, 14);
    checkOutput("held_done_count", doneCount - done0, 1);
    @(negedge clock);

    markBase();
    applyStimulus(1'b0, 6'd8, 32'hFF);
    clocks = 0;
    while ((shiftEdges - shift0) < 4 && clocks < 100) begin
      @(negedge clock);
      clocks++;
    end
    checkOutput("abort_reached_bit3", shiftEdges - shift0, 4);
    checkOutput("abort_tck_high", tck, 1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("abort_pins", {tck, tms, tdi, busy, done}, 5'b01010);
    checkOutput("abort_tdo_data", tdoData, 0);
    repeat (3) @(negedge clock);
    checkOutput("abort_no_done", doneCount - done0, 0);
    markBase();
    reset_n = 1'b1;
    waitIdle(40, clocks);
    checkOutput("abort_tlr_clocks", clocks, 12);
    checkOutput("abort_tlr_tms", packTms(tms0, 6), 64'h1F);
    checkOutput("abort_tlr_tck", tckRises - rise0, 6);
    checkOutput("abort_tap_state", tapState, RTI);
    checkOutput("abort_no_done_after", doneCount - done0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
